// File: rtl/uart_ingress_mux.sv
// Per-channel UART byte FIFOs merged round-robin into a single registered output stage.
// Define UART_INGRESS_MUX_XOFF_EN to add per-channel xoff flow control with hysteresis.
module uart_ingress_mux #(
  parameter int CHANNELS    = 4,
  parameter int DEPTH       = 16,
  parameter int XOFF_MARGIN = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CHANNELS-1:0]   in_valid,
  input  logic [8*CHANNELS-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic [2:0]            out_chan,
`ifdef UART_INGRESS_MUX_XOFF_EN
  output logic [CHANNELS-1:0]   xoff,
`endif
  output logic [CHANNELS-1:0]   ovf,
  input  logic [CHANNELS-1:0]   ovf_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [CHANNELS-1:0]            full;
  logic [CHANNELS-1:0]            nonempty;
  logic [CHANNELS-1:0]            wr_en;
  logic [CHANNELS-1:0]            pop;
  logic [CHANNELS-1:0]            ovf_set;
  logic [CHANNELS-1:0][7:0]       head_data;
  logic [CHANNELS-1:0][CNT_W-1:0] count;
  logic                           load;
  logic                           grant_valid;
  logic [2:0]                     grant;
  logic [2:0]                     rr_ptr;
  logic [7:0]                     grant_data;

  assign load = !out_valid || out_ready;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;

    // Fullness uses the registered count, so a same-cycle pop never makes room for a write.
    assign count[c]     = cnt;
    assign full[c]      = (cnt == CNT_W'(DEPTH));
    assign nonempty[c]  = (cnt != '0);
    assign wr_en[c]     = in_valid[c] && !full[c];
    assign ovf_set[c]   = in_valid[c] && full[c];
    assign pop[c]       = load && grant_valid && (grant == 3'(c));
    assign head_data[c] = mem[rd_ptr];

    always_ff @(posedge clk) begin
      if (wr_en[c]) mem[wr_ptr] <= in_data[8*c +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (wr_en[c]) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop[c])   rd_ptr <= rd_ptr + PTR_W'(1);
        if (wr_en[c] && !pop[c])      cnt <= cnt + CNT_W'(1);
        else if (!wr_en[c] && pop[c]) cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Rotating priority: first non-empty channel at or above rr_ptr, else wrap to the lowest.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    grant_data  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (!grant_valid && nonempty[c] && (c >= int'(rr_ptr))) begin
        grant_valid = 1'b1;
        grant       = 3'(c);
        grant_data  = head_data[c];
      end
    end
    for (int c = 0; c < CHANNELS; c++) begin
      if (!grant_valid && nonempty[c] && (c < int'(rr_ptr))) begin
        grant_valid = 1'b1;
        grant       = 3'(c);
        grant_data  = head_data[c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      out_valid <= grant_valid;
      if (grant_valid) begin
        out_data <= grant_data;
        out_chan <= grant;
        rr_ptr   <= (grant == 3'(CHANNELS - 1)) ? 3'd0 : grant + 3'd1;
      end
    end
  end

  // A new overflow in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf <= '0;
    else        ovf <= (ovf & ~ovf_clr) | ovf_set;
  end

`ifdef UART_INGRESS_MUX_XOFF_EN
  localparam int XOFF_ON  = DEPTH - XOFF_MARGIN;
  localparam int XOFF_OFF = DEPTH / 2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xoff <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (count[c] >= CNT_W'(XOFF_ON))       xoff[c] <= 1'b1;
        else if (count[c] <= CNT_W'(XOFF_OFF)) xoff[c] <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_ingress_mux.sv
// Directed self-checking bench for uart_ingress_mux (default parameters).
// The xoff checks are compiled only when UART_INGRESS_MUX_XOFF_EN is defined.
module tb_uart_ingress_mux;

  localparam int CHANNELS    = 4;
  localparam int DEPTH       = 16;
  localparam int XOFF_MARGIN = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic [CHANNELS-1:0]   in_valid = '0;
  logic [8*CHANNELS-1:0] in_data = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [7:0]            out_data;
  logic [2:0]            out_chan;
  logic [CHANNELS-1:0]   ovf;
  logic [CHANNELS-1:0]   ovf_clr = '0;
`ifdef UART_INGRESS_MUX_XOFF_EN
  logic [CHANNELS-1:0]   xoff;
`endif

  int checks = 0;
  int errors = 0;

  uart_ingress_mux #(
    .CHANNELS(CHANNELS),
    .DEPTH(DEPTH),
    .XOFF_MARGIN(XOFF_MARGIN)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_chan(out_chan),
`ifdef UART_INGRESS_MUX_XOFF_EN
    .xoff(xoff),
`endif
    .ovf(ovf),
    .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkStage(input string tag, input logic v, input logic [7:0] d, input logic [2:0] ch);
    checkOutput({tag, ".valid"}, 32'(out_valid), 32'(v));
    checkOutput({tag, ".data"}, 32'(out_data), 32'(d));
    checkOutput({tag, ".chan"}, 32'(out_chan), 32'(ch));
  endtask

  // All driving and sampling happens 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] chanWord(input int ch, input logic [7:0] b);
    return 32'(b) << (8 * ch);
  endfunction

  task automatic applyStimulus(input logic [CHANNELS-1:0] v, input logic [31:0] d);
    in_valid = v;
    in_data  = d;
    tick();
    in_valid = '0;
    in_data  = '0;
  endtask

  task automatic doReset();
    rst_n     = 1'b0;
    in_valid  = '0;
    ovf_clr   = '0;
    out_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    $display("[TB] start");

    // Asynchronous reset before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    checkStage("reset", 1'b0, 8'h00, 3'd0);
    checkOutput("reset.ovf", 32'(ovf), 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;

    // Single byte on channel 2, written on the first edge after release.
    out_ready = 1'b1;
    applyStimulus(4'b0100, chanWord(2, 8'h41));
    checkOutput("single.nobypass", 32'(out_valid), 32'h0);
    tick();
    checkStage("single.out", 1'b1, 8'h41, 3'd2);
    tick();
    checkOutput("single.empty", 32'(out_valid), 32'h0);

    // Channels 0, 1, 3 in the same cycle drain in round-robin order.
    doReset();
    out_ready = 1'b1;
    applyStimulus(4'b1011, chanWord(0, 8'h10) | chanWord(1, 8'h11) | chanWord(3, 8'h13));
    tick();
    checkStage("rr.first", 1'b1, 8'h10, 3'd0);
    tick();
    checkStage("rr.second", 1'b1, 8'h11, 3'd1);
    tick();
    checkStage("rr.third", 1'b1, 8'h13, 3'd3);
    tick();
    checkOutput("rr.empty", 32'(out_valid), 32'h0);

    // Two channels with two bytes each alternate, including pointer wrap.
    doReset();
    out_ready = 1'b1;
    applyStimulus(4'b0101, chanWord(0, 8'h01) | chanWord(2, 8'h21));
    checkOutput("alt.nobypass", 32'(out_valid), 32'h0);
    applyStimulus(4'b0101, chanWord(0, 8'h02) | chanWord(2, 8'h22));
    checkStage("alt.b0", 1'b1, 8'h01, 3'd0);
    tick();
    checkStage("alt.b1", 1'b1, 8'h21, 3'd2);
    tick();
    checkStage("alt.b2", 1'b1, 8'h02, 3'd0);
    tick();
    checkStage("alt.b3", 1'b1, 8'h22, 3'd2);
    tick();
    checkOutput("alt.empty", 32'(out_valid), 32'h0);

    // Overflow: 17 bytes fill stage and FIFO, the 18th is dropped.
    doReset();
    for (int k = 0; k < 17; k++) applyStimulus(4'b0010, chanWord(1, 8'(8'h20 + k)));
    checkOutput("ovf.notyet", 32'(ovf), 32'h0);
    checkStage("ovf.stage", 1'b1, 8'h20, 3'd1);
    ovf_clr = 4'b0010;
    applyStimulus(4'b0010, chanWord(1, 8'h31));
    checkOutput("ovf.setwins", 32'(ovf), 32'h2);
    tick();
    ovf_clr = '0;
    checkOutput("ovf.cleared", 32'(ovf), 32'h0);
    out_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      checkStage($sformatf("ovf.drain%0d", k), 1'b1, 8'(8'h20 + k), 3'd1);
      tick();
    end
    checkOutput("ovf.dropped", 32'(out_valid), 32'h0);

    // Stalled output stays stable while channel 0 keeps writing.
    doReset();
    applyStimulus(4'b0001, chanWord(0, 8'hA0));
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i < 3) applyStimulus(4'b0001, chanWord(0, 8'(8'hA1 + i)));
      else tick();
      checkStage($sformatf("stall%0d", i), 1'b1, 8'hA0, 3'd0);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checkStage($sformatf("stall.drain%0d", k), 1'b1, 8'(8'hA0 + k), 3'd0);
      tick();
    end
    checkOutput("stall.empty", 32'(out_valid), 32'h0);

    // Mid-transfer reset discards buffered bytes and the held output.
    doReset();
    for (int k = 0; k < 5; k++) applyStimulus(4'b0100, chanWord(2, 8'(8'h51 + k)));
    checkStage("rst.before", 1'b1, 8'h51, 3'd2);
    #2 rst_n = 1'b0;
    #1;
    checkStage("rst.async", 1'b0, 8'h00, 3'd0);
    checkOutput("rst.ovf", 32'(ovf), 32'h0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) tick();
    checkStage("rst.noreplay", 1'b0, 8'h00, 3'd0);
    applyStimulus(4'b1000, chanWord(3, 8'h77));
    tick();
    checkStage("rst.newbyte", 1'b1, 8'h77, 3'd3);
    tick();
    checkOutput("rst.empty", 32'(out_valid), 32'h0);

`ifdef UART_INGRESS_MUX_XOFF_EN
    // 13 writes leave 12 in the FIFO (one in the stage); hysteresis between 12 and 8.
    doReset();
    for (int k = 0; k < 12; k++) applyStimulus(4'b0001, chanWord(0, 8'(k)));
    tick();
    checkOutput("xoff.count11", 32'(xoff[0]), 32'h0);
    applyStimulus(4'b0001, chanWord(0, 8'h0C));
    tick();
    checkOutput("xoff.count12", 32'(xoff[0]), 32'h1);
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    tick();
    checkOutput("xoff.count9", 32'(xoff[0]), 32'h1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    checkOutput("xoff.count8", 32'(xoff[0]), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
